// File: rtl/dii_worm_arbiter_mux.sv
// ----------------------------------------------------------------------------
// dii_worm_arbiter_mux
//
// Merges CHANNELS dii_flit input streams into one registered output stream.
// The flits of one worm are never interleaved with the flits of another worm.
// Worms are arbitrated either round-robin (RR_ARB=1) or by fixed priority,
// where the lowest index wins (RR_ARB=0).
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   in_flit      CHANNELS input flits {valid, last, data}
//   in_ready     per-input ready; at most one bit is set
//   out_flit     registered output flit
//   out_ready    downstream ready
//   grant        channel owning the current or most recent worm
//   worm_active  high while a multi-flit worm holds the lock
//   worm_cnt     number of last flits accepted at the inputs (wraps)
// ----------------------------------------------------------------------------
package dii_pkg;
   localparam int DII_DATA_W = 16;

   typedef struct packed {
      logic                  valid;
      logic                  last;
      logic [DII_DATA_W-1:0] data;
   } dii_flit;
endpackage

module dii_worm_arbiter_mux
   import dii_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int RR_ARB   = 1,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  dii_flit                     in_flit [CHANNELS],
   output logic [CHANNELS-1:0]         in_ready,
   output dii_flit                     out_flit,
   input  logic                        out_ready,
   output logic [$clog2(CHANNELS)-1:0] grant,
   output logic                        worm_active,
   output logic [CNT_W-1:0]            worm_cnt
);

   localparam int GW = $clog2(CHANNELS);
   localparam int SW = GW + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state;
   logic [GW-1:0]   rr_ptr;

   logic            can_load;
   logic [GW-1:0]   pick;
   logic            pick_found;
   logic [GW-1:0]   sel;
   logic            sel_valid;
   dii_flit         sel_flit;
   logic            xfer;

   // Channel that follows ch in round-robin order.
   function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] ch);
      if (ch == GW'(CHANNELS - 1)) begin
         return '0;
      end
      return ch + GW'(1);
   endfunction

   // The register can take a new flit when it is empty or being drained.
   assign can_load = out_ready | ~out_flit.valid;

   // Pick a requester. Fixed mode scans upward from 0, round-robin mode
   // scans upward from rr_ptr and wraps at CHANNELS.
   always_comb begin
      logic [SW-1:0] pos;
      logic [GW-1:0] idx;
      pick       = '0;
      pick_found = 1'b0;
      pos        = '0;
      idx        = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         pos = SW'(k);
         if (RR_ARB != 0) begin
            pos = pos + {1'b0, rr_ptr};
         end
         if (pos >= SW'(CHANNELS)) begin
            pos = pos - SW'(CHANNELS);
         end
         idx = pos[GW-1:0];
         if (!pick_found && in_flit[idx].valid) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   // While locked, only the owning channel is served, bubbles or not.
   // This keeps in_ready independent of every other channel's valid.
   always_comb begin
      sel       = (state == LOCKED) ? grant : pick;
      sel_valid = (state == LOCKED) | pick_found;
      sel_flit  = in_flit[sel];
      in_ready  = '0;
      if (sel_valid) begin
         in_ready[sel] = can_load;
      end
      xfer = sel_valid & can_load & sel_flit.valid;
   end

   // Output register stage and worm FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_flit    <= '0;
         state       <= IDLE;
         rr_ptr      <= '0;
         grant       <= '0;
         worm_active <= 1'b0;
         worm_cnt    <= '0;
      end else begin
         if (xfer) begin
            out_flit.valid <= 1'b1;
            out_flit.last  <= sel_flit.last;
            out_flit.data  <= sel_flit.data;
         end else if (out_ready) begin
            out_flit.valid <= 1'b0;
         end

         if (xfer) begin
            grant <= sel;
            if (sel_flit.last) begin
               state       <= IDLE;
               worm_active <= 1'b0;
               worm_cnt    <= worm_cnt + CNT_W'(1);
               if (RR_ARB != 0) begin
                  rr_ptr <= ptr_after(sel);
               end
            end else begin
               state       <= LOCKED;
               worm_active <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dii_worm_arbiter_mux.sv
// ----------------------------------------------------------------------------
// tb_dii_worm_arbiter_mux
//
// Directed bench for dii_worm_arbiter_mux. Two instances with CHANNELS=4 and
// CNT_W=4: dut_rr (round-robin) carries most scenarios, dut_fx (fixed
// priority) is used for the priority scenario. Inputs change on the falling
// edge; in_ready is sampled just after that and registered outputs just after
// the rising edge.
// ----------------------------------------------------------------------------
module tb_dii_worm_arbiter_mux;
   import dii_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   dii_flit    a_in [4];
   logic [3:0] a_rdy;
   dii_flit    a_out;
   logic       a_ordy;
   logic [1:0] a_grant;
   logic       a_act;
   logic [3:0] a_cnt;

   dii_flit    b_in [4];
   logic [3:0] b_rdy;
   dii_flit    b_out;
   logic       b_ordy;
   logic [1:0] b_grant;
   logic       b_act;
   logic [3:0] b_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dii_worm_arbiter_mux #(.CHANNELS(4), .RR_ARB(1), .CNT_W(4)) dut_rr (
      .clk(clk), .rst(rst), .in_flit(a_in), .in_ready(a_rdy),
      .out_flit(a_out), .out_ready(a_ordy), .grant(a_grant),
      .worm_active(a_act), .worm_cnt(a_cnt));

   dii_worm_arbiter_mux #(.CHANNELS(4), .RR_ARB(0), .CNT_W(4)) dut_fx (
      .clk(clk), .rst(rst), .in_flit(b_in), .in_ready(b_rdy),
      .out_flit(b_out), .out_ready(b_ordy), .grant(b_grant),
      .worm_active(b_act), .worm_cnt(b_cnt));

   function automatic dii_flit mk(input logic v, input logic l, input logic [15:0] d);
      dii_flit f;
      f.valid = v;
      f.last  = l;
      f.data  = d;
      return f;
   endfunction

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) begin
         a_in[i] = '0;
         b_in[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      a_ordy = 1'b1;
      b_ordy = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      a_ordy = 1'b1;
      b_ordy = 1'b1;
      rst    = 1'b1;
      #2;
      n_checks++;
      if (a_out !== '0) begin
         n_fail++; $display("FAIL reset_out: got %h expected 0", a_out);
      end
      n_checks++;
      if (a_grant !== 2'd0 || a_act !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: grant=%0d act=%b expected 0/0", a_grant, a_act);
      end
      n_checks++;
      if (a_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt);
      end
      n_checks++;
      if (a_rdy !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 0000", a_rdy);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_worm();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_in[2] = mk(1'b1, (i == 2), 16'h00A1 + 16'(i));
         #1;
         n_checks++;
         if (a_rdy !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready[%0d]: got %b expected 0100", i, a_rdy);
         end
         @(posedge clk); #1;
         n_checks++;
         if (a_out !== mk(1'b1, (i == 2), 16'h00A1 + 16'(i))) begin
            n_fail++; $display("FAIL single_out[%0d]: got %h expected %h", i, a_out,
                               mk(1'b1, (i == 2), 16'h00A1 + 16'(i)));
         end
         n_checks++;
         if (a_act !== (i != 2) || a_grant !== 2'd2) begin
            n_fail++; $display("FAIL single_ctrl[%0d]: act=%b grant=%0d expected %b/2",
                               i, a_act, a_grant, (i != 2));
         end
      end
      @(negedge clk);
      a_in[2] = '0;
      @(posedge clk); #1;
      n_checks++;
      if (a_out.valid !== 1'b0 || a_cnt !== 4'd1) begin
         n_fail++; $display("FAIL single_end: valid=%b cnt=%0d expected 0/1", a_out.valid, a_cnt);
      end
   endtask

   // rr_ptr is 3 here; ch1 wins first, ch0 waits behind the lock.
   task automatic test_lock();
      dii_flit    ch1 [7];
      dii_flit    ch0 [7];
      logic [3:0] rdy [7];
      logic       ov  [7];
      logic [15:0] od [7];
      logic       act [7];
      logic [1:0] gr  [7];
      ch1 = '{mk(1,0,16'h00B1), mk(1,0,16'h00B2), '0, '0, mk(1,0,16'h00B3), mk(1,1,16'h00B4), '0};
      ch0 = '{'0, mk(1,1,16'h00C0), mk(1,1,16'h00C0), mk(1,1,16'h00C0),
              mk(1,1,16'h00C0), mk(1,1,16'h00C0), mk(1,1,16'h00C0)};
      rdy = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
      ov  = '{1, 1, 0, 0, 1, 1, 1};
      od  = '{16'h00B1, 16'h00B2, 16'h0000, 16'h0000, 16'h00B3, 16'h00B4, 16'h00C0};
      act = '{1, 1, 1, 1, 1, 0, 0};
      gr  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         a_in[1] = ch1[c];
         a_in[0] = ch0[c];
         #1;
         n_checks++;
         if (a_rdy !== rdy[c]) begin
            n_fail++; $display("FAIL lock_ready[%0d]: got %b expected %b", c, a_rdy, rdy[c]);
         end
         @(posedge clk); #1;
         n_checks++;
         if (a_out.valid !== ov[c] || (ov[c] && a_out.data !== od[c])) begin
            n_fail++; $display("FAIL lock_out[%0d]: got v=%b d=%h expected v=%b d=%h",
                               c, a_out.valid, a_out.data, ov[c], od[c]);
         end
         n_checks++;
         if (a_act !== act[c] || a_grant !== gr[c]) begin
            n_fail++; $display("FAIL lock_ctrl[%0d]: act=%b grant=%0d expected %b/%0d",
                               c, a_act, a_grant, act[c], gr[c]);
         end
      end
      @(negedge clk);
      clear_inputs();
      @(posedge clk); #1;
      n_checks++;
      if (a_cnt !== 4'd3) begin
         n_fail++; $display("FAIL lock_cnt: got %0d expected 3", a_cnt);
      end
   endtask

   task automatic test_rr_fairness();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) a_in[i] = mk(1'b1, 1'b1, 16'h0010 + 16'(i));
         #1;
         n_checks++;
         if (a_rdy !== (4'b0001 << (k % 4))) begin
            n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, a_rdy, 4'b0001 << (k % 4));
         end
         @(posedge clk); #1;
         n_checks++;
         if (a_grant !== 2'(k % 4) || a_out.data !== 16'h0010 + 16'(k % 4) || a_out.valid !== 1'b1) begin
            n_fail++; $display("FAIL rr_out[%0d]: grant=%0d data=%h expected %0d/%h",
                               k, a_grant, a_out.data, k % 4, 16'h0010 + 16'(k % 4));
         end
         n_checks++;
         if (a_cnt !== 4'(k + 1)) begin
            n_fail++; $display("FAIL rr_cnt[%0d]: got %0d expected %0d", k, a_cnt, k + 1);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_fixed_priority();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) b_in[i] = mk(1'b1, 1'b1, 16'h0010 + 16'(i));
         #1;
         n_checks++;
         if (b_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL fixed_ready[%0d]: got %b expected 0001", k, b_rdy);
         end
         @(posedge clk); #1;
         n_checks++;
         if (b_grant !== 2'd0 || b_out.data !== 16'h0010 || b_cnt !== 4'(k + 1)) begin
            n_fail++; $display("FAIL fixed_out[%0d]: grant=%0d data=%h cnt=%0d expected 0/0010/%0d",
                               k, b_grant, b_out.data, b_cnt, k + 1);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   // Five-flit worm on ch3 with out_ready stalls; the source offers the
   // flit it still owes each cycle.
   task automatic test_backpressure();
      logic        ordy [9];
      int          off  [9];
      logic [3:0]  rdy  [9];
      logic        ov   [9];
      logic [15:0] od   [9];
      logic        act  [9];
      ordy = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
      off  = '{1, 2, 2, 2, 3, 4, 4, 5, 0};
      rdy  = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
      ov   = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      od   = '{16'h00D1, 16'h00D1, 16'h00D1, 16'h00D2, 16'h00D3, 16'h00D3, 16'h00D4, 16'h00D5, 16'h0000};
      act  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         a_ordy  = ordy[c];
         a_in[3] = (off[c] == 0) ? '0 : mk(1'b1, (off[c] == 5), 16'h00D0 + 16'(off[c]));
         #1;
         n_checks++;
         if (a_rdy !== rdy[c]) begin
            n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", c, a_rdy, rdy[c]);
         end
         @(posedge clk); #1;
         n_checks++;
         if (a_out.valid !== ov[c] || (ov[c] && a_out.data !== od[c]) || a_act !== act[c]) begin
            n_fail++; $display("FAIL bp_out[%0d]: v=%b d=%h act=%b expected v=%b d=%h act=%b",
                               c, a_out.valid, a_out.data, a_act, ov[c], od[c], act[c]);
         end
      end
      @(negedge clk);
      clear_inputs();
      a_ordy = 1'b1;
      #1;
      n_checks++;
      if (a_cnt !== 4'd9) begin
         n_fail++; $display("FAIL bp_cnt: got %0d expected 9", a_cnt);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a_in[2] = mk(1'b1, 1'b0, 16'h00E0 + 16'(i));
         @(posedge clk); #1;
      end
      n_checks++;
      if (a_act !== 1'b1 || a_out.valid !== 1'b1) begin
         n_fail++; $display("FAIL arst_pre: act=%b valid=%b expected 1/1", a_act, a_out.valid);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (a_out.valid !== 1'b0 || a_act !== 1'b0 || a_cnt !== 4'd0 || a_grant !== 2'd0) begin
         n_fail++; $display("FAIL arst_now: valid=%b act=%b cnt=%0d grant=%0d expected all 0",
                            a_out.valid, a_act, a_cnt, a_grant);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      a_in[1] = mk(1'b1, 1'b1, 16'h0055);
      #1;
      n_checks++;
      if (a_rdy !== 4'b0010) begin
         n_fail++; $display("FAIL arst_idle_ready: got %b expected 0010", a_rdy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (a_out !== mk(1'b1, 1'b1, 16'h0055) || a_grant !== 2'd1 || a_cnt !== 4'd1) begin
         n_fail++; $display("FAIL arst_after: out=%h grant=%0d cnt=%0d expected %h/1/1",
                            a_out, a_grant, a_cnt, mk(1'b1, 1'b1, 16'h0055));
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_counter_wrap();
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         a_in[1] = mk(1'b1, 1'b1, 16'h0100 + 16'(k));
         #1;
         n_checks++;
         if (a_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected 0010", k, a_rdy);
         end
         @(posedge clk); #1;
         if (k == 15) begin
            n_checks++;
            if (a_cnt !== 4'd0) begin
               n_fail++; $display("FAIL wrap_cnt16: got %0d expected 0", a_cnt);
            end
         end
      end
      n_checks++;
      if (a_cnt !== 4'd1 || a_out.data !== 16'h0110) begin
         n_fail++; $display("FAIL wrap_cnt17: cnt=%0d data=%h expected 1/0110", a_cnt, a_out.data);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_worm();
      test_lock();
      test_rr_fairness();
      test_fixed_priority();
      test_backpressure();
      test_async_reset();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dii_worm_arbiter_mux.md
# dii_worm_arbiter_mux

Parametrised N-input wormhole multiplexer for the debug interconnect (DII) ring router. It merges `CHANNELS` dii_flit input streams into one registered output stream, never interleaving flits of different worms. Arbitration between worms is either fixed-priority or round-robin. It replaces the two-input ring/local mux wherever a router stage needs more sources, fair sharing, or a registered output for timing closure.

## Interface
Parameters:
- `CHANNELS`, 2: number of input streams, 2..16. Index 0 is the ring/through path.
- `RR_ARB`, 1: 1 = round-robin between worms; 0 = fixed priority, lowest index wins.
- `CNT_W`, 16: width of the completed-worm counter.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_flit`  in  dii_flit[CHANNELS]  input flits (`valid`, `last`, `data`).
- `in_ready`  out  [CHANNELS]  per-input ready.
- `out_flit`  out  dii_flit  registered output flit.
- `out_ready`  in  1  downstream ready.
- `grant`  out  $clog2(CHANNELS)  channel owning the current or most recent worm.
- `worm_active`  out  1  a multi-flit worm is locked.
- `worm_cnt`  out  CNT_W  count of last flits accepted at the inputs; wraps modulo 2^CNT_W.

## Operation
- Handshake on any port: a transfer occurs in a cycle where valid=1 and ready=1.
- Output register holds one flit.
  - `can_load = out_ready | ~out_flit.valid`.
  - On an input transfer, the register loads the flit with valid=1.
  - Otherwise, if `out_ready` is high, the register clears its valid bit.
- IDLE state:
  - The arbiter picks a requester combinationally from the inputs with valid=1.
  - Fixed mode: the lowest requesting index wins.
  - RR mode: the first requesting index at or after `rr_ptr`, scanning upward with wrap, wins.
  - Only the winner sees `in_ready = can_load`. All other `in_ready` are 0.
  - `grant` updates to the winner when its first flit transfers.
  - If that flit has `last=0`, go to LOCKED.
- LOCKED state:
  - Only `in_ready[grant] = can_load`. All other inputs are held off, even if valid.
  - Bubbles on the granted input (valid=0) do not release the lock.
  - A transfer with `last=1` returns the block to IDLE.
- Pointer update in RR mode: on every transfer of a last flit, `rr_ptr <= grant+1`, wrapping from CHANNELS-1 to 0. This applies to single-flit worms accepted in IDLE too.
- `worm_cnt` increments by 1 on every input transfer with `last=1`.
- `worm_active` is 1 exactly in LOCKED.
- The data and last fields of `out_flit` are don't-care when its valid bit is 0.

## Timing
- Reset values, asynchronous:
  - Every `out_flit` field is 0 and `out_flit.valid=0`.
  - State is IDLE, `rr_ptr=0`, `grant=0`, `worm_active=0`, `worm_cnt=0`.
  - A reset in the middle of a worm drops the worm silently. There is no recovery.
- Latency: an input transfer at edge t makes the flit visible on `out_flit` from t to t+1.
- Throughput: one flit per cycle while `out_ready` stays high.
- The combinational path `out_ready` -> `in_ready` is allowed. There is no path from input data to output data.
- Worm boundary: if a last flit transfers at cycle c, a different channel's first flit can transfer at c+1. No bubble is inserted.
- Back-to-back worms from the same channel:
  - Fixed mode: allowed.
  - RR mode: allowed only when no other channel requests.
- Backpressure: with `out_ready=0` and the register full, all `in_ready` are 0 and the state holds.
- Simultaneous requests in IDLE: exactly one winner. Within a worm, all flits come from one channel.
- `in_ready` never depends on the `valid` of a non-winning channel.

## Test plan
- Reset and single worm:
  - Stimulus: CHANNELS=4. Ch2 sends a 3-flit worm (data 0xA1,0xA2,0xA3) with `out_ready=1`.
  - Required: output flits appear on cycles 1..3 after acceptance. `worm_active` is high for 2 cycles. `worm_cnt=1`. `grant=2`.
- Lock against interference:
  - Stimulus: ch1 starts a 4-flit worm; ch0 raises valid mid-worm; ch1 inserts a 2-cycle bubble.
  - Required: ch0 `in_ready=0` until ch1's last flit transfers. The output carries only ch1 flits, in order.
- Round-robin fairness:
  - Stimulus: RR_ARB=1, all 4 channels continuously offer single-flit worms.
  - Required: output channel order is 0,1,2,3,0,... and `worm_cnt` increments every cycle.
- Fixed priority:
  - Stimulus: RR_ARB=0, same stimulus as the round-robin test.
  - Required: only ch0 is ever granted.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1 during a 5-flit worm.
  - Required: no flit lost or duplicated, order preserved, and the register is held while stalled.
- Reset and counter wrap:
  - Stimulus: assert `rst` asynchronously in the middle of a worm.
  - Required: `out_flit.valid` drops immediately and state is IDLE afterwards.
  - Stimulus: CNT_W=4, send 17 worms.
  - Required: `worm_cnt=1`.
